mycpu_pcu: RTL

MYCPU_PCU -- requirements
Module: mycpu_pcu

---
 rtl/mycpu_pcu.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/mycpu_pcu.sv
// Program-counter unit: PC sequencing (INC/BRA/JMP) plus an optional LIFO call stack.
// Define MYCPU_PCU_CALLSTACK_EN to build CALL/RET with the stack and the sticky err flag.
module mycpu_pcu #(
  parameter int              AW       = 8,
  parameter int              DEPTH    = 4,
  parameter logic [AW-1:0]   RESET_PC = '0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         en,
  input  logic [2:0]                   pc_op,
  input  logic                         bra_cond,
  input  logic [AW-1:0]                offset,
  input  logic [AW-1:0]                jmp_addr,
  output logic [AW-1:0]                pc,
  output logic [$clog2(DEPTH+1)-1:0]   sp,
  output logic                         stack_empty,
  output logic                         stack_full,
  output logic                         err
);

  typedef enum logic [2:0] {
    OP_NOP  = 3'b000,
    OP_INC  = 3'b001,
    OP_BRA  = 3'b010,
    OP_JMP  = 3'b011,
    OP_CALL = 3'b100,
    OP_RET  = 3'b101
  } pc_op_e;

  logic [AW-1:0] pc_q, pc_d, pc_inc, pc_bra;
  logic          advance;

  assign pc_inc = pc_q + AW'(1);
  assign pc_bra = pc_q + offset;

`ifdef MYCPU_PCU_CALLSTACK_EN
  localparam int SPW   = $clog2(DEPTH + 1);
  localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SLOTS = 1 << IW;

  logic [AW-1:0]  stack_mem [SLOTS];
  logic [SPW-1:0] sp_q, sp_d;
  logic           empty_q, full_q, err_q;
  logic           do_push, do_pop, set_err;
  logic [IW-1:0]  wr_idx, rd_idx;

  assign wr_idx  = sp_q[IW-1:0];
  assign rd_idx  = wr_idx - IW'(1);
  // Once err is set the unit is halted until reset.
  assign advance = en & ~err_q;
`else
  assign advance = en;
`endif

  // NOTE: every signal assigned in this block gets a default first, so no path
  // through the case leaves one unassigned and no latch is inferred.
  always_comb begin
    pc_d = pc_q;
`ifdef MYCPU_PCU_CALLSTACK_EN
    do_push = 1'b0;
    do_pop  = 1'b0;
    set_err = 1'b0;
`endif
    case (pc_op)
      OP_INC: pc_d = pc_inc;
      OP_BRA: pc_d = bra_cond ? pc_bra : pc_inc;
      OP_JMP: pc_d = jmp_addr;
      OP_CALL: begin
`ifdef MYCPU_PCU_CALLSTACK_EN
        if (full_q) begin
          set_err = 1'b1;
        end else begin
          pc_d    = jmp_addr;
          do_push = 1'b1;
        end
`else
        pc_d = jmp_addr;
`endif
      end
      OP_RET: begin
`ifdef MYCPU_PCU_CALLSTACK_EN
        if (empty_q) begin
          set_err = 1'b1;
        end else begin
          pc_d   = stack_mem[rd_idx];
          do_pop = 1'b1;
        end
`endif
      end
      default: ;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else if (advance) begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

`ifdef MYCPU_PCU_CALLSTACK_EN
  always_comb begin
    sp_d = sp_q;
    if (do_push) begin
      sp_d = sp_q + SPW'(1);
    end else if (do_pop) begin
      sp_d = sp_q - SPW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp_q    <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      err_q   <= 1'b0;
    end else if (advance) begin
      sp_q    <= sp_d;
      empty_q <= (sp_d == '0);
      full_q  <= (sp_d == SPW'(DEPTH));
      err_q   <= set_err;
    end
  end

  // NOTE: the stack storage has no reset; entries above sp are never read, so
  // clearing them would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (advance && do_push) begin
      stack_mem[wr_idx] <= pc_inc;
    end
  end

  assign sp          = sp_q;
  assign stack_empty = empty_q;
  assign stack_full  = full_q;
  assign err         = err_q;
`else
  assign sp          = '0;
  assign stack_empty = 1'b1;
  assign stack_full  = 1'b0;
  assign err         = 1'b0;
`endif

endmodule
